// File: rtl/reg_select_scoreboard.sv
// Register select/encode unit: IR latch, Ra/Rb/Rc decode to one-hot enables, C immediate, pending-write scoreboard.
// Define SELENC_PIPE_EN to register the decode outputs (1-cycle latency); default build is combinational.
module reg_select_scoreboard #(
  parameter int AW     = 4,
  parameter int DATA_W = 32,
  parameter int RA_LSB = 23,
  parameter int RB_LSB = 19,
  parameter int RC_LSB = 15,
  parameter int IMM_W  = 18,
  localparam int NREGS = 2**AW
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              ir_load,
  input  logic [DATA_W-1:0] ir_in,
  input  logic              Gra,
  input  logic              Grb,
  input  logic              Grc,
  input  logic              Rin,
  input  logic              Rout,
  input  logic              BAout,
  input  logic              sb_set,
  input  logic              sb_clr,
  input  logic [AW-1:0]     sb_clr_idx,
  output logic [NREGS-1:0]  reg_in,
  output logic [NREGS-1:0]  reg_out,
  output logic              zero_sel,
  output logic [DATA_W-1:0] c_sign_ext,
  output logic [AW-1:0]     sel_idx,
  output logic              sel_err,
  output logic              hazard,
  output logic [NREGS-1:0]  busy,
  output logic [AW:0]       busy_cnt
);

  function automatic logic [AW:0] popcount(input logic [NREGS-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + (AW+1)'(v[i]);
    return c;
  endfunction

  logic [DATA_W-1:0] ir_q, ir_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [AW:0]       cnt_q, cnt_d;

  // Clear is applied before set so a same-index set/clear leaves the register busy.
  always_comb begin
    ir_d   = ir_load ? ir_in : ir_q;
    busy_d = busy_q;
    if (sb_clr) busy_d[sb_clr_idx] = 1'b0;
    if (sb_set) busy_d[ir_q[RA_LSB +: AW]] = 1'b1;
    cnt_d  = popcount(busy_d);
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      ir_q   <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      ir_q   <= ir_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy       = busy_q;
  assign busy_cnt   = cnt_q;
  assign c_sign_ext = {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};

  logic [1:0]       g_cnt;
  logic             g_one, rd_req;
  logic [AW-1:0]    sel_idx_c;
  logic             sel_err_c, hazard_c, zero_sel_c;
  logic [NREGS-1:0] onehot, reg_in_c, reg_out_c;

  always_comb begin
    g_cnt     = {1'b0, Gra} + {1'b0, Grb} + {1'b0, Grc};
    g_one     = (g_cnt == 2'd1);
    sel_err_c = (g_cnt >= 2'd2);
    rd_req    = Rout | BAout;
    sel_idx_c = '0;
    if (g_one) begin
      if (Gra)      sel_idx_c = ir_q[RA_LSB +: AW];
      else if (Grb) sel_idx_c = ir_q[RB_LSB +: AW];
      else          sel_idx_c = ir_q[RC_LSB +: AW];
    end
    onehot     = NREGS'(1) << sel_idx_c;
    hazard_c   = rd_req & g_one & busy_q[sel_idx_c];
    // Base-address read of R0 means the bus drives constant zero, not the register.
    zero_sel_c = BAout & g_one & (sel_idx_c == '0);
    reg_in_c   = (Rin & g_one) ? onehot : '0;
    reg_out_c  = (rd_req & g_one & ~hazard_c & ~zero_sel_c) ? onehot : '0;
  end

`ifdef SELENC_PIPE_EN
  always_ff @(posedge clock) begin
    if (!clear) begin
      reg_in   <= '0;
      reg_out  <= '0;
      zero_sel <= 1'b0;
      sel_idx  <= '0;
      sel_err  <= 1'b0;
      hazard   <= 1'b0;
    end else begin
      reg_in   <= reg_in_c;
      reg_out  <= reg_out_c;
      zero_sel <= zero_sel_c;
      sel_idx  <= sel_idx_c;
      sel_err  <= sel_err_c;
      hazard   <= hazard_c;
    end
  end
`else
  assign reg_in   = reg_in_c;
  assign reg_out  = reg_out_c;
  assign zero_sel = zero_sel_c;
  assign sel_idx  = sel_idx_c;
  assign sel_err  = sel_err_c;
  assign hazard   = hazard_c;
`endif

endmodule
